priority_encoder8_to_3: RTL and testbench
=========================================

# priority_encoder8_to_3

Registered 8-to-3 priority encoder with request latching and a valid/ready output handshake. It is the encoding counterpart to the 3-to-8 decoder. Request lines are captured into a pending register, and one pending index at a time is presented as a 3-bit code. The serviced bit is cleared when the consumer accepts the code. It sits between event/interrupt sources and any consumer that expects a binary index, e.g. a 3-to-8 decoder driving acknowledge lines.

## Interface
- No parameters; widths fixed at 8 requests / 3-bit code.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  8  request lines, sampled every edge; a 1 in any cycle marks that index pending.
- ready  input  1  consumer accepts `out` this cycle when `valid` is also high.
- out  output  3  encoded index of the granted request, registered.
- valid  output  1  `out` holds a granted index, registered.
- pending  output  8  current pending register P, registered.
- count  output  4  number of set bits in P (0..8), registered, updated with P.

## Operation
- **Pending register:**
  - P_next = (P & ~clr) | in.
  - clr is the one-hot of `out` when valid && ready, else 0.
  - Set dominates clear: a request on the bit being cleared in the same cycle leaves it pending.
- **FSM, two states:**
  - IDLE (valid=0): at an edge with P != 0, load out = sel(P), set valid=1, go to HOLD. Otherwise stay.
  - HOLD (valid=1): out is held stable regardless of new requests, including higher-priority ones.
  - HOLD exit: at an edge with ready=1, clear the granted bit, set valid=0, go to IDLE. With ready=0, stay.
- **Selection sel(P), default:** fixed priority, highest set index wins (bit 7 highest).
- **Encoding:** out is a binary index 0..7. P == 0 never produces a grant. out keeps its last value while valid=0.
- **count:** population count of P_next, registered alongside P, zero-extended to 4 bits. A value of 8 must be reachable.
- **Reset (rst=1 at an edge):**
  - P=0, count=0, pending=0, out=3'b000, valid=0, state IDLE; round-robin pointer=7 (see Configuration).
  - Requests on `in` during that edge are discarded.
  - Reset mid-HOLD drops valid at that edge without a handshake.
- **ready while valid=0:** ignored, clears nothing.

## Timing
- **Request-to-valid latency:** request sampled at edge E sets P at E. With the FSM in IDLE, valid=1 and the matching out appear after edge E+1 (2 edges from `in` to `valid`).
- **Handshake:** valid && ready at edge H clears the bit at H, and valid is low for the cycle after H.
- **Next grant:** if P is still nonzero, the next grant appears after edge H+1. Minimum one idle cycle between grants gives a peak throughput of one grant per 2 cycles.
- **Output stability:** out and valid change only at a reset edge, an IDLE-to-HOLD edge, or a handshake edge.
- **Simultaneous events:** at a handshake edge, new `in` bits and the clear apply in the same update. A re-request of the granted bit keeps it pending and it can be granted again.

## Configuration
- **PRIO_ENC_ROUND_ROBIN_EN defined:**
  - sel(P) searches upward from (last+1) mod 8, wrapping, and takes the first set bit.
  - `last` is a 3-bit register updated to `out` at each handshake edge; reset value 7, so the search starts at index 0.
- **Not defined:** fixed highest-index priority as above. No `last` register is instantiated, and there is no other behavioural difference.

## Test plan
- **Reset state:** hold rst=1 for 2 cycles with in=8'hFF. Required: valid=0, out=0, pending=0, count=0. Release with in=0: valid stays 0.
- **Single request latency:** pulse in=8'b0010_0000 for one cycle with ready=0. Required: pending=8'h20 and count=1 after that edge; valid=1, out=3'd5 one edge later; both held for 10 cycles.
- **Fixed priority and stability:**
  - Load P=8'b0000_1010, with the grant out=3 waiting.
  - Pulse in=8'h80 while ready=0: out stays 3.
  - Assert ready: grants follow in order 3, 7, 1, each separated by one valid=0 cycle.
  - Final pending=0, count=0.
- **Set-dominates-clear:** with out=4, valid=1, drive ready=1 and in=8'h10 in the same cycle. Required: pending bit 4 remains 1, and out=4 is granted again two edges later.
- **Full occupancy and reset mid-operation:**
  - Pulse in=8'hFF: count=8.
  - After two handshakes (outs 7, 6): count=6.
  - Assert rst during HOLD: valid=0 and pending=0 at that edge.
- **PRIO_ENC_ROUND_ROBIN_EN:** with P=8'hFF and ready=1 constant, the grant sequence is 0,1,2,…,7,0.

Source files
------------

// File: rtl/priority_encoder8_to_3_if.sv
// -----------------------------------------------------------------------------
// priority_encoder8_to_3_if
//
// Purpose:
//   Groups the request, handshake and status signals of the 8-to-3 priority
//   encoder. The clock and reset are not part of this interface. They stay as
//   plain ports on the encoder.
//
// Signals:
//   in       [7:0]  request lines. A 1 marks that index pending.
//   ready           the consumer accepts `out` when `valid` is also high.
//   out      [2:0]  encoded index of the granted request.
//   valid           `out` holds a granted index.
//   pending  [7:0]  current pending register.
//   count    [3:0]  number of set bits in the pending register (0..8).
//
// Modports:
//   master  the environment side. It drives requests and ready, and observes
//           the code and status.
//   slave   the encoder side. It consumes requests and ready, and drives the
//           code and status.
// -----------------------------------------------------------------------------
interface priority_encoder8_to_3_if;
    logic [7:0] in;
    logic       ready;
    logic [2:0] out;
    logic       valid;
    logic [7:0] pending;
    logic [3:0] count;

    modport master (
        output in,
        output ready,
        input  out,
        input  valid,
        input  pending,
        input  count
    );

    modport slave (
        input  in,
        input  ready,
        output out,
        output valid,
        output pending,
        output count
    );
endinterface : priority_encoder8_to_3_if

// File: rtl/priority_encoder8_to_3.sv
// -----------------------------------------------------------------------------
// priority_encoder8_to_3
//
// Purpose:
//   A registered 8-to-3 priority encoder. It latches requests and drives a
//   valid/ready handshake on its output.
//   - Requests on `in` accumulate in a pending register P.
//   - The encoder grants one pending index at a time as a 3-bit code.
//   - The granted bit is cleared when the consumer accepts the code.
//   - A two-state FSM holds the code stable until it is accepted.
//   - There is at least one idle cycle between successive grants.
//
// Ports:
//   clk   single clock. All state updates on its rising edge.
//   rst   synchronous, active-high reset.
//   bus   priority_encoder8_to_3_if.slave
//         inputs:  in, ready
//         outputs: out, valid, pending, count
//
// Configuration:
//   PRIO_ENC_ROUND_ROBIN_EN
//     Defined: the grant search starts one index above the last accepted
//       code and wraps around. A 3-bit `last` register is added for this.
//     Undefined (default): fixed priority. The highest set index wins.
// -----------------------------------------------------------------------------
module priority_encoder8_to_3 (
    input  logic                    clk,
    input  logic                    rst,
    priority_encoder8_to_3_if.slave bus
);

    // -------------------------------------------------------------------------
    // Types and state
    // -------------------------------------------------------------------------
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [3:0] count_q, count_d;
    logic [2:0] out_q, out_d;

    logic       handshake;
    logic [7:0] clr;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [2:0] last_q, last_d;
`endif

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    // Returns the population count of an 8-bit vector, zero-extended to 4 bits.
    // The 4-bit width is needed so that a full register (8) is representable.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    // Searches upward from (last + 1) mod 8, wrapping, and returns the first
    // set index. The 3-bit addition wraps naturally. At k = 8 the candidate
    // is `last` itself, so every index is visited exactly once.
    function automatic logic [2:0] sel_grant(input logic [7:0] p,
                                             input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] cand;
        logic       found;
        idx   = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!found && p[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction
`else
    // Fixed priority. The ascending scan keeps the last hit, which is the
    // highest set index (bit 7 is the highest priority).
    function automatic logic [2:0] sel_grant(input logic [7:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments only. All
    // flops then update together from their pre-edge values, with no
    // ordering races between processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= 8'h00;
            count_q   <= 4'd0;
            out_q     <= 3'd0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            last_q    <= 3'd7;  // the first search then starts at index 0
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            out_q     <= out_d;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the
    // block. A path that leaves a variable unassigned would otherwise infer
    // a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // The grant decision looks at the registered P. A request
                // seen at edge E is therefore granted at edge E+1.
                if (pending_q != 8'h00) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        handshake = (state_q == S_HOLD) && bus.ready;
        // While valid is low, ready is ignored, so clr is only non-zero on an
        // accepted grant.
        clr       = handshake ? (8'b0000_0001 << out_q) : 8'h00;
        // Set dominates clear. A request on the bit being cleared keeps it
        // pending.
        pending_d = (pending_q & ~clr) | bus.in;
        count_d   = popcount8(pending_d);

        // out only changes on an IDLE-to-HOLD edge. It holds its value in
        // HOLD and while valid is low.
        out_d = out_q;
        if ((state_q == S_IDLE) && (pending_q != 8'h00)) begin
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            out_d = sel_grant(pending_q, last_q);
`else
            out_d = sel_grant(pending_q);
`endif
        end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
        last_d = handshake ? out_q : last_q;
`endif
    end

    // -------------------------------------------------------------------------
    // Output ports. All of them come straight from flops. valid is decoded
    // from the one-bit state register.
    // -------------------------------------------------------------------------
    assign bus.out     = out_q;
    assign bus.valid   = (state_q == S_HOLD);
    assign bus.pending = pending_q;
    assign bus.count   = count_q;

endmodule : priority_encoder8_to_3

// File: tb/tb_priority_encoder8_to_3.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder8_to_3
//
// Purpose:
//   Self-checking bench for priority_encoder8_to_3.
//   - A behavioural model tracks the pending set, the current grant and the
//     handshake using plain set arithmetic.
//   - One compare process checks every output against the model at each
//     falling edge.
//   - Directed sections pin the model with hand-computed literals. A
//     randomized phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_priority_encoder8_to_3;

    logic clk;
    logic rst;
    priority_encoder8_to_3_if bus_if ();

    priority_encoder8_to_3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit compare_en = 1'b0;

    // ---------------------------------------------------------------- model
    logic [7:0] m_pend;
    bit         m_valid;
    int         m_out;
    int         m_last;

    // Returns the index the specification grants from pending set p.
    function automatic int pick(input logic [7:0] p, input int last);
        int r;
        r = -1;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= 8 && r < 0; k++) begin
            if (p[(last + k) % 8]) r = (last + k) % 8;
        end
`else
        for (int i = 7; i >= 0 && r < 0; i--) begin
            if (p[i]) r = i;
        end
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        logic [7:0] nxt;
        if (rst) begin
            m_pend  = 8'h00;
            m_valid = 1'b0;
            m_out   = 0;
            m_last  = 7;
        end else begin
            nxt = m_pend;
            if (m_valid && bus_if.ready) begin
                nxt[m_out] = 1'b0;
                m_last     = m_out;
                m_valid    = 1'b0;
            end else if (!m_valid && m_pend != 8'h00) begin
                m_out   = pick(m_pend, m_last);
                m_valid = 1'b1;
            end
            m_pend = nxt | bus_if.in;
        end
    end

    // ---------------------------------------------------------------- check
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            check("model valid", 32'(bus_if.valid), 32'(m_valid));
            check("model out", 32'(bus_if.out), 32'(m_out));
            check("model pending", 32'(bus_if.pending), 32'(m_pend));
            check("model count", 32'(bus_if.count), 32'($countones(m_pend)));
        end
    end

    // Applies one set of inputs at a falling edge and returns at the next
    // falling edge, after the rising edge has consumed the inputs.
    task automatic tick(input logic [7:0] i_in, input logic i_ready,
                        input logic i_rst);
        bus_if.in    = i_in;
        bus_if.ready = i_ready;
        rst          = i_rst;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        bus_if.in    = 8'h00;
        bus_if.ready = 1'b0;
        rst          = 1'b1;
        @(negedge clk);

        // Reset state, with requests present during reset.
        tick(8'hFF, 1'b0, 1'b1);
        tick(8'hFF, 1'b0, 1'b1);
        compare_en = 1'b1;
        check("rst valid", 32'(bus_if.valid), 32'd0);
        check("rst out", 32'(bus_if.out), 32'd0);
        check("rst pending", 32'(bus_if.pending), 32'h00);
        check("rst count", 32'(bus_if.count), 32'd0);
        tick(8'h00, 1'b0, 1'b0);
        check("post-rst valid", 32'(bus_if.valid), 32'd0);

        // Single request latency and hold.
        tick(8'h20, 1'b0, 1'b0);
        check("lat pending", 32'(bus_if.pending), 32'h20);
        check("lat count", 32'(bus_if.count), 32'd1);
        check("lat valid early", 32'(bus_if.valid), 32'd0);
        tick(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("lat valid", 32'(bus_if.valid), 32'd1);
            check("lat out", 32'(bus_if.out), 32'd5);
            tick(8'h00, 1'b0, 1'b0);
        end
        tick(8'h00, 1'b1, 1'b0);
        check("lat drain", 32'(bus_if.pending), 32'h00);

        // Set dominates clear.
        tick(8'h10, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        check("sdc first out", 32'(bus_if.out), 32'd4);
        tick(8'h10, 1'b1, 1'b0);
        check("sdc pending", 32'(bus_if.pending), 32'h10);
        check("sdc valid low", 32'(bus_if.valid), 32'd0);
        tick(8'h00, 1'b0, 1'b0);
        check("sdc regrant valid", 32'(bus_if.valid), 32'd1);
        check("sdc regrant out", 32'(bus_if.out), 32'd4);
        tick(8'h00, 1'b1, 1'b0);

`ifdef PRIO_ENC_ROUND_ROBIN_EN
        // Round-robin sequence with every request line held high.
        begin
            int exp_seq;
            int seen;
            tick(8'h00, 1'b0, 1'b1);
            exp_seq = 0;
            seen    = 0;
            for (int c = 0; c < 40 && seen < 9; c++) begin
                tick(8'hFF, 1'b1, 1'b0);
                if (bus_if.valid) begin
                    check("rr order", 32'(bus_if.out), 32'(exp_seq));
                    exp_seq = (exp_seq + 1) % 8;
                    seen++;
                end
            end
            check("rr grants seen", 32'(seen), 32'd9);
            tick(8'h00, 1'b0, 1'b1);
        end
`else
        // Fixed priority and stability while holding.
        tick(8'h0A, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        check("fp first", 32'(bus_if.out), 32'd3);
        tick(8'h80, 1'b0, 1'b0);
        check("fp stable", 32'(bus_if.out), 32'd3);
        check("fp stable valid", 32'(bus_if.valid), 32'd1);
        tick(8'h00, 1'b1, 1'b0);
        check("fp gap1", 32'(bus_if.valid), 32'd0);
        tick(8'h00, 1'b1, 1'b0);
        check("fp second", 32'(bus_if.out), 32'd7);
        tick(8'h00, 1'b1, 1'b0);
        check("fp gap2", 32'(bus_if.valid), 32'd0);
        tick(8'h00, 1'b1, 1'b0);
        check("fp third", 32'(bus_if.out), 32'd1);
        tick(8'h00, 1'b1, 1'b0);
        check("fp final pending", 32'(bus_if.pending), 32'h00);
        check("fp final count", 32'(bus_if.count), 32'd0);

        // Full occupancy, then reset in the middle of a hold.
        tick(8'hFF, 1'b0, 1'b0);
        check("full count", 32'(bus_if.count), 32'd8);
        tick(8'h00, 1'b0, 1'b0);
        check("full g1", 32'(bus_if.out), 32'd7);
        tick(8'h00, 1'b1, 1'b0);
        tick(8'h00, 1'b1, 1'b0);
        check("full g2", 32'(bus_if.out), 32'd6);
        tick(8'h00, 1'b1, 1'b0);
        check("full count6", 32'(bus_if.count), 32'd6);
        tick(8'h00, 1'b0, 1'b0);
        check("full hold", 32'(bus_if.valid), 32'd1);
        tick(8'h00, 1'b0, 1'b1);
        check("midrst valid", 32'(bus_if.valid), 32'd0);
        check("midrst pending", 32'(bus_if.pending), 32'h00);
`endif

        // Randomized phase. Sparse requests, random ready, rare resets.
        for (int c = 0; c < 600; c++) begin
            logic [7:0] r_in;
            r_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            tick(r_in, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        compare_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_priority_encoder8_to_3
